// File: rtl/uart_pkg.sv
// Shared UART definitions: rx state encoding, parity modes and the default bit period.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_e;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   localparam int CLKS_PER_BIT_115200 = 434;

   // Out-of-range frame lengths fall back to the full word width.
   function automatic logic [3:0] uart_eff_nbits(input logic [3:0] n, input int max_w);
      if ((n < 4'd5) || (int'(n) > max_w))
         return 4'(max_w);
      else
         return n;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the Rx pin plus a registered falling-edge detector.
module uart_rx_sync (
   input  logic Clk,
   input  logic Rst_n,
   input  logic Rx,
   output logic Rxs,
   output logic StartEdge
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q, prev_d;
   logic fall_q, fall_d;

   always_comb begin
      sync1_d = Rx;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      fall_d  = prev_q & ~sync2_q;
   end

   // Line idles high, so the chain resets to 1 to avoid a spurious edge.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         fall_q  <= fall_d;
      end
   end

   assign Rxs       = sync2_q;
   assign StartEdge = fall_q;

endmodule

// File: rtl/uart_rx_param.sv
// UART receiver with runtime frame format, error flags and a one-entry valid/ready buffer.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
   parameter int DATA_W       = 8
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              RxEn,
   input  logic              Rx,
   input  logic [3:0]        NBits,
   input  logic [1:0]        ParityMode,
   input  logic              StopBits,
   output logic [DATA_W-1:0] RxData,
   output logic              RxValid,
   input  logic              RxReady,
   output logic              RxDone,
   output logic              ParityErr,
   output logic              FrameErr,
   output logic              Overrun
);

   localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]       DW4      = 4'(DATA_W);

   logic rxs;
   logic start_edge;

   uart_rx_sync u_sync (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .Rx        (Rx),
      .Rxs       (rxs),
      .StartEdge (start_edge)
   );

   rx_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [3:0]        nbits_q, nbits_d;
   logic [1:0]        pmode_q, pmode_d;
   logic              stop2_q, stop2_d;
   logic              stop_idx_q, stop_idx_d;
   logic              par_acc_q, par_acc_d;
   logic              perr_q, perr_d;
   logic              ferr_q, ferr_d;
   logic [DATA_W-1:0] shift_q, shift_d;

   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              done_q, done_d;
   logic              perr_buf_q, perr_buf_d;
   logic              ferr_buf_q, ferr_buf_d;
   logic              ovr_q, ovr_d;

   logic commit;
   logic frame_ferr;
   logic par_en;
   logic handshake;

   assign par_en = (pmode_q == PAR_EVEN) || (pmode_q == PAR_ODD);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_cnt_d  = bit_cnt_q;
      nbits_d    = nbits_q;
      pmode_d    = pmode_q;
      stop2_d    = stop2_q;
      stop_idx_d = stop_idx_q;
      par_acc_d  = par_acc_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      shift_d    = shift_q;
      commit     = 1'b0;
      frame_ferr = ferr_q;

      case (state_q)
         IDLE: begin
            if (RxEn && start_edge) begin
               state_d = START;
               cnt_d   = '0;
               nbits_d = uart_eff_nbits(NBits, DATA_W);
               pmode_d = ParityMode;
               stop2_d = StopBits;
            end
         end
         START: begin
            if (cnt_q == CNT_HALF) begin
               if (rxs) begin
                  state_d = IDLE;
               end else begin
                  state_d    = DATA;
                  cnt_d      = '0;
                  bit_cnt_d  = '0;
                  shift_d    = '0;
                  par_acc_d  = 1'b0;
                  perr_d     = 1'b0;
                  ferr_d     = 1'b0;
                  stop_idx_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d     = '0;
               // Bits enter at the MSB; the commit shifts them down to right-justify.
               shift_d   = {rxs, shift_q[DATA_W-1:1]};
               par_acc_d = par_acc_q ^ rxs;
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == (nbits_q - 4'd1))
                  state_d = par_en ? PARITY : STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PARITY: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               perr_d  = par_acc_q ^ rxs ^ (pmode_q == PAR_ODD);
               state_d = STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d      = '0;
               frame_ferr = ferr_q | ~rxs;
               ferr_d     = frame_ferr;
               if (stop2_q && !stop_idx_q) begin
                  stop_idx_d = 1'b1;
               end else begin
                  commit  = 1'b1;
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if ((state_q != IDLE) && !RxEn) begin
         state_d = IDLE;
         commit  = 1'b0;
      end
   end

   assign handshake = valid_q & RxReady;

   always_comb begin
      data_d     = data_q;
      valid_d    = valid_q;
      done_d     = 1'b0;
      perr_buf_d = perr_buf_q;
      ferr_buf_d = ferr_buf_q;
      ovr_d      = ovr_q;

      if (handshake) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
      // A frame read out in this same cycle frees the buffer for the new one.
      if (commit) begin
         if (!valid_q || handshake) begin
            data_d     = shift_q >> (DW4 - nbits_q);
            perr_buf_d = perr_q;
            ferr_buf_d = frame_ferr;
            valid_d    = 1'b1;
            done_d     = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_cnt_q  <= '0;
         nbits_q    <= DW4;
         pmode_q    <= PAR_NONE;
         stop2_q    <= 1'b0;
         stop_idx_q <= 1'b0;
         par_acc_q  <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         shift_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         perr_buf_q <= 1'b0;
         ferr_buf_q <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         nbits_q    <= nbits_d;
         pmode_q    <= pmode_d;
         stop2_q    <= stop2_d;
         stop_idx_q <= stop_idx_d;
         par_acc_q  <= par_acc_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
         perr_buf_q <= perr_buf_d;
         ferr_buf_q <= ferr_buf_d;
         ovr_q      <= ovr_d;
      end
   end

   assign RxData    = data_q;
   assign RxValid   = valid_q;
   assign RxDone    = done_q;
   assign ParityErr = perr_buf_q;
   assign FrameErr  = ferr_buf_q;
   assign Overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed and randomized frames driven onto Rx, checked against a frame-level reference model.
module tb_uart_rx_param;

   localparam int C  = 16;
   localparam int DW = 8;

   logic          Clk = 1'b0;
   logic          Rst_n = 1'b0;
   logic          RxEn = 1'b0;
   logic          Rx = 1'b1;
   logic [3:0]    NBits = 4'd8;
   logic [1:0]    ParityMode = 2'b00;
   logic          StopBits = 1'b0;
   logic          RxReady = 1'b0;
   logic [DW-1:0] RxData;
   logic          RxValid;
   logic          RxDone;
   logic          ParityErr;
   logic          FrameErr;
   logic          Overrun;

   int vectors = 0;
   int miscompares = 0;
   int done_cnt = 0;
   logic [9:0] cap_q[$];

   uart_rx_param #(.CLKS_PER_BIT(C), .DATA_W(DW)) dut (
      .Clk        (Clk),
      .Rst_n      (Rst_n),
      .RxEn       (RxEn),
      .Rx         (Rx),
      .NBits      (NBits),
      .ParityMode (ParityMode),
      .StopBits   (StopBits),
      .RxData     (RxData),
      .RxValid    (RxValid),
      .RxReady    (RxReady),
      .RxDone     (RxDone),
      .ParityErr  (ParityErr),
      .FrameErr   (FrameErr),
      .Overrun    (Overrun)
   );

   always #5 Clk = ~Clk;

   always @(negedge Clk) begin
      if (RxDone) begin
         done_cnt = done_cnt + 1;
         cap_q.push_back({ParityErr, FrameErr, RxData});
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int eff_n(input logic [3:0] n);
      if ((n < 4'd5) || (int'(n) > DW)) return DW;
      return int'(n);
   endfunction

   // Expected buffered result {ParityErr, FrameErr, RxData} for one frame.
   function automatic logic [9:0] expect_frame(input logic [7:0] d, input logic [3:0] n,
                                               input logic [1:0] pm, input bit flip, input bit badstop);
      logic [7:0] full;
      logic [7:0] m;
      logic       pe;
      full = 8'hFF;
      m    = d & (full >> (8 - eff_n(n)));
      pe   = ((pm == 2'b01) || (pm == 2'b10)) && flip;
      return {pe, badstop, m};
   endfunction

   task automatic idle(input int k);
      repeat (k) @(negedge Clk);
   endtask

   task automatic bit_time(input logic b);
      Rx = b;
      repeat (C) @(negedge Clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic [3:0] n, input logic [1:0] pm,
                             input bit s2, input bit flip, input bit badstop, input bit hold_low);
      int         ne;
      logic [7:0] full;
      logic [7:0] m;
      logic       par;
      ne   = eff_n(n);
      full = 8'hFF;
      m    = d & (full >> (8 - ne));
      NBits      = n;
      ParityMode = pm;
      StopBits   = s2;
      par = (^m) ^ (pm == 2'b10) ^ flip;
      bit_time(1'b0);
      for (int i = 0; i < ne; i++) bit_time(m[i]);
      if ((pm == 2'b01) || (pm == 2'b10)) bit_time(par);
      bit_time(s2 ? 1'b1 : logic'(~badstop));
      if (s2) bit_time(logic'(~badstop));
      Rx = hold_low ? 1'b0 : 1'b1;
   endtask

   task automatic read_out();
      RxReady = 1'b1;
      @(negedge Clk);
      RxReady = 1'b0;
   endtask

   initial begin
      int         d0;
      logic [9:0] exp;
      logic [9:0] exp_q[$];
      logic [9:0] got;
      logic [7:0] rd;
      logic [3:0] rn;
      logic [1:0] rpm;
      bit         rs2, rflip, rbad;

      repeat (3) @(negedge Clk);
      chk("reset_data", 32'(RxData), 32'h0);
      chk("reset_valid", 32'(RxValid), 32'h0);
      chk("reset_done", 32'(RxDone), 32'h0);
      chk("reset_perr", 32'(ParityErr), 32'h0);
      chk("reset_ferr", 32'(FrameErr), 32'h0);
      chk("reset_ovr", 32'(Overrun), 32'h0);
      Rst_n = 1'b1;
      RxEn  = 1'b1;
      idle(2 * C);

      d0 = done_cnt;
      send_frame(8'hA5, 4'd8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(2);
      chk("a5_data", 32'(RxData), 32'hA5);
      chk("a5_valid", 32'(RxValid), 32'h1);
      chk("a5_done_once", 32'(done_cnt - d0), 32'h1);
      chk("a5_done_low", 32'(RxDone), 32'h0);
      chk("a5_perr", 32'(ParityErr), 32'h0);
      chk("a5_ferr", 32'(FrameErr), 32'h0);
      read_out();
      chk("a5_read_valid", 32'(RxValid), 32'h0);
      chk("a5_read_data_kept", 32'(RxData), 32'hA5);
      idle(C);

      send_frame(8'h5A, 4'd7, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(2);
      chk("even_ok_data", 32'(RxData), 32'h5A);
      chk("even_ok_perr", 32'(ParityErr), 32'h0);
      read_out();
      idle(C);
      send_frame(8'h5A, 4'd7, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(2);
      chk("even_bad_data", 32'(RxData), 32'h5A);
      chk("even_bad_perr", 32'(ParityErr), 32'h1);
      read_out();
      idle(C);

      d0 = done_cnt;
      send_frame(8'h3C, 4'd8, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
      idle(2);
      chk("stop2_data", 32'(RxData), 32'h3C);
      chk("stop2_ferr", 32'(FrameErr), 32'h1);
      chk("stop2_perr", 32'(ParityErr), 32'h0);
      read_out();
      idle(30 * C);
      chk("break_no_frames", 32'(done_cnt - d0), 32'h1);
      chk("break_valid", 32'(RxValid), 32'h0);
      Rx = 1'b1;
      idle(2 * C);

      d0 = done_cnt;
      Rx = 1'b0;
      idle(4);
      Rx = 1'b1;
      idle(3 * C);
      chk("glitch_valid", 32'(RxValid), 32'h0);
      chk("glitch_done", 32'(done_cnt - d0), 32'h0);

      d0 = done_cnt;
      send_frame(8'h11, 4'd8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(C);
      send_frame(8'h22, 4'd8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(2);
      chk("ovr_data", 32'(RxData), 32'h11);
      chk("ovr_flag", 32'(Overrun), 32'h1);
      chk("ovr_valid", 32'(RxValid), 32'h1);
      chk("ovr_done_once", 32'(done_cnt - d0), 32'h1);
      read_out();
      chk("ovr_read_valid", 32'(RxValid), 32'h0);
      chk("ovr_read_flag", 32'(Overrun), 32'h0);
      idle(C);

      d0 = done_cnt;
      fork
         send_frame(8'h77, 4'd8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
         begin
            idle(4 * C);
            RxEn = 1'b0;
         end
      join
      idle(C);
      RxEn = 1'b1;
      idle(C);
      send_frame(8'h12, 4'd8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(2);
      chk("abort_data", 32'(RxData), 32'h12);
      chk("abort_done_once", 32'(done_cnt - d0), 32'h1);
      read_out();
      idle(C);

      for (int k = 0; k < 24; k++) begin
         rd    = 8'($urandom);
         rn    = 4'($urandom_range(0, 15));
         rpm   = 2'($urandom_range(0, 3));
         rs2   = 1'($urandom_range(0, 1));
         rflip = 1'($urandom_range(0, 1));
         rbad  = 1'($urandom_range(0, 1));
         exp   = expect_frame(rd, rn, rpm, rflip, rbad);
         d0    = done_cnt;
         send_frame(rd, rn, rpm, rs2, rflip, rbad, 1'b0);
         idle(2);
         chk("rand_data", 32'(RxData), 32'(exp[7:0]));
         chk("rand_perr", 32'(ParityErr), 32'(exp[9]));
         chk("rand_ferr", 32'(FrameErr), 32'(exp[8]));
         chk("rand_valid", 32'(RxValid), 32'h1);
         chk("rand_done_once", 32'(done_cnt - d0), 32'h1);
         read_out();
         idle(C);
      end

      RxReady = 1'b1;
      cap_q.delete();
      for (int k = 0; k < 6; k++) begin
         rd    = 8'($urandom);
         rn    = 4'($urandom_range(5, 8));
         rpm   = 2'($urandom_range(0, 3));
         rs2   = 1'($urandom_range(0, 1));
         rflip = 1'($urandom_range(0, 1));
         exp_q.push_back(expect_frame(rd, rn, rpm, rflip, 1'b0));
         send_frame(rd, rn, rpm, rs2, rflip, 1'b0, 1'b0);
      end
      idle(2);
      chk("b2b_count", 32'(cap_q.size()), 32'd6);
      while ((cap_q.size() > 0) && (exp_q.size() > 0)) begin
         got = cap_q.pop_front();
         exp = exp_q.pop_front();
         chk("b2b_frame", 32'(got), 32'(exp));
      end
      chk("b2b_ovr", 32'(Overrun), 32'h0);
      chk("b2b_valid_drained", 32'(RxValid), 32'h0);
      RxReady = 1'b0;
      idle(C);

      send_frame(8'h81, 4'd8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(C);
      send_frame(8'h42, 4'd8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(C);
      chk("pre_rst_valid", 32'(RxValid), 32'h1);
      chk("pre_rst_ovr", 32'(Overrun), 32'h1);
      fork
         send_frame(8'hF0, 4'd8, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
         begin
            idle(5 * C);
            #2;
            Rst_n = 1'b0;
            #1;
            chk("rst_data", 32'(RxData), 32'h0);
            chk("rst_valid", 32'(RxValid), 32'h0);
            chk("rst_done", 32'(RxDone), 32'h0);
            chk("rst_perr", 32'(ParityErr), 32'h0);
            chk("rst_ferr", 32'(FrameErr), 32'h0);
            chk("rst_ovr", 32'(Overrun), 32'h0);
         end
      join
      Rst_n = 1'b1;
      idle(2 * C);
      chk("post_rst_valid", 32'(RxValid), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receive engine for the serial front end, the next generation of the fixed-format receiver. It adds runtime-selectable data length (5 to DATA_W bits), optional even/odd parity, one or two stop bits, false-start rejection, framing/parity/overrun error reporting, and a one-entry output buffer with a valid/ready handshake. It sits between the board Rx pin and the command/sensor parser, which drains frames at its own pace.

## Interface
- CLKS_PER_BIT, 434: Clk cycles per bit (50 MHz / 115200). Legal range is 4 or more.
- DATA_W, 8: maximum data bits and the RxData width. Legal range is 5..9.
- Clk  in  1  system clock.
- Rst_n  in  1  reset, asynchronous, active-low.
- RxEn  in  1  receive enable. Low means the block is held in or returns to IDLE.
- Rx  in  1  asynchronous serial line, idle high.
- NBits  in  4  data bits per frame. Values outside 5..DATA_W are treated as DATA_W.
- ParityMode  in  2  parity: 00 none, 01 even, 10 odd, 11 none.
- StopBits  in  1  0 selects one stop bit; 1 selects two.
- RxData  out  DATA_W  received word, LSB-first on the line, right-justified, unused MSBs 0. Reset value 0.
- RxValid  out  1  RxData and flags hold an unread frame. Reset value 0.
- RxReady  in  1  consumer accepts the frame when RxValid & RxReady.
- RxDone  out  1  one-cycle pulse when a frame is written to the buffer. Reset value 0.
- ParityErr  out  1  parity mismatch on the buffered frame. Reset value 0.
- FrameErr  out  1  a stop bit was sampled low on the buffered frame. Reset value 0.
- Overrun  out  1  sticky; set when a completed frame was dropped. Reset value 0.

## Operation
- Rx is passed through a 2-flop synchronizer; all sampling uses the synchronized value rxs. Start detection is on the falling edge of rxs (previous 1, current 0) in IDLE with RxEn=1.
- NBits, ParityMode and StopBits are latched at start detection. Changes mid-frame have no effect.
- States:
  - IDLE: on a start edge, go to START and clear the bit counter.
  - START: at count CLKS_PER_BIT/2, sample rxs. If it is 1 (false start), return to IDLE. Otherwise zero the counter and go to DATA.
  - DATA: sample at each count CLKS_PER_BIT-1 and shift the bit in LSB-first. After the NBits-th sample, go to PARITY if parity is enabled, otherwise go to STOP.
  - PARITY: sample, then compare. Even parity means the XOR of data and parity bit is 0; odd parity means it is 1.
  - STOP: sample one or two stop bits. Any low stop sample sets the frame's FrameErr. After the last stop sample, commit and go to IDLE.
- Commit happens in the cycle of the last stop sample:
  - If RxValid=0: load RxData, ParityErr and FrameErr, set RxValid, pulse RxDone.
  - If RxValid=1: drop the frame, set Overrun, pulse no RxDone. The buffered frame is unchanged.
- Handshake: RxValid & RxReady clears RxValid and Overrun on the next edge. RxData and the error flags keep their last values until the next commit.
- A handshake and a commit in the same cycle: the new frame is loaded, RxValid stays 1, and Overrun is not set.
- RxEn low in any state except IDLE aborts the frame on the next edge. No commit, no flags, and the buffer is untouched.
- A line held low after a framing error (break) does not retrigger, because a start needs a fresh falling edge.
- Rst_n low at any point clears all state and outputs immediately and returns the block to IDLE.

## Timing
- Counter width is $clog2(CLKS_PER_BIT). It wraps to 0 on each sample.
- Latency from the Rx falling edge to the start-edge flag is 2 synchronizer cycles plus 1 edge-detect cycle.
- RxValid and RxDone assert one Clk after the final stop sample. This is about (1+N+P+S-0.5)·CLKS_PER_BIT + 3 cycles after the Rx falling edge, where N is data bits, P is 1 if parity is enabled, and S is the number of stop bits.
- RxValid deasserts the edge after the handshake. The consumer may hold RxReady high permanently.
- Sustained back-to-back frames with RxReady=1 never overrun.

## Structure
- Shared package uart_pkg holds:
  - the rx state enum (IDLE, START, DATA, PARITY, STOP);
  - parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - the default CLKS_PER_BIT_115200 constant.
  The tx successor reuses this package.
- Sub-module uart_rx_sync contains the 2-flop synchronizer plus falling-edge detector, reset to 1 (line idle).
- The state machine, counters, shift register and output buffer live in the top module.

## Test plan
- CLKS_PER_BIT=16, NBits=8, no parity, 1 stop; send 0xA5 -> RxData=0xA5, RxValid=1, RxDone one pulse, ParityErr=FrameErr=0.
- NBits=7, even parity; send 0x5A with correct parity bit 0 -> ParityErr=0. Resend with parity bit 1 -> RxData=0x5A, ParityErr=1.
- Two stop bits; drive the second stop low while sending 0x3C -> RxData=0x3C, FrameErr=1. A held-low line afterwards produces no further frames.
- Glitch: Rx low for 4 clocks, then high -> START rejects it and the block returns to IDLE; RxValid stays 0 and no RxDone.
- RxReady=0; send 0x11 then 0x22 -> RxData=0x11, Overrun=1. Raise RxReady for 1 cycle -> RxValid=0, Overrun=0.
- Drop RxEn mid-DATA of 0x77, then reassert and send 0x12 -> only 0x12 is received. Assert Rst_n low mid-frame -> all outputs are 0 immediately.
